// File: rtl/digital_pkg.sv
// digital_scan shared types and the 7-segment code map.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package digital_pkg;

  typedef enum logic {
    BLANK,
    SHOW
  } scan_state_t;

  localparam logic [6:0] SEG_BLANK = 7'b111_1111;

  function automatic logic [6:0] seg_decode(
    input logic [3:0] code
  );
    unique case (code)
      4'h0:    seg_decode = 7'b100_0000;
      4'h1:    seg_decode = 7'b111_1001;
      4'h2:    seg_decode = 7'b010_0100;
      4'h3:    seg_decode = 7'b011_0000;
      4'h4:    seg_decode = 7'b001_1001;
      4'h5:    seg_decode = 7'b001_0010;
      4'h6:    seg_decode = 7'b000_0010;
      4'h7:    seg_decode = 7'b111_1000;
      4'h8:    seg_decode = 7'b000_0000;
      4'h9:    seg_decode = 7'b001_0000;
      4'hA:    seg_decode = 7'b000_1000;
      4'hB:    seg_decode = 7'b000_0011;
      4'hC:    seg_decode = 7'b100_0110;
      4'hD:    seg_decode = 7'b010_0001;
      4'hE:    seg_decode = 7'b000_0110;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Slot counter, digit index and BLANK/SHOW FSM.
// Exposes next-cycle values so the top can register outputs in step.
module scan_timer #(
  parameter  int DIGITS       = 8,
  parameter  int SCAN_DIV     = 50000,
  parameter  int BLANK_CYCLES = 16,
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1,
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic [CW-1:0] cnt_nx,
  output logic [IW-1:0] idx_nx,
  output logic          show_nx,
  output logic          frame_start
);
  import digital_pkg::*;

  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  scan_state_t   state, state_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      idx   <= '0;
      state <= BLANK;
    end else begin
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      state <= state_nx;
    end
  end

  always_comb begin
    cnt_nx = cnt + 1'b1;
    idx_nx = idx;
    if (rst) begin
      cnt_nx = '0;
      idx_nx = '0;
    end else if (cnt == CNT_LAST) begin
      cnt_nx = '0;
      idx_nx = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
    state_nx = (cnt_nx >= CNT_SHOW) ? SHOW : BLANK;
  end

  always_comb begin
    show_nx     = (state_nx == SHOW);
    frame_start = (cnt == '0) && (idx == '0);
  end

endmodule

// File: rtl/digital_scan.sv
// Multiplexed common-anode 7-segment driver with per-frame
// snapshot, dead-time blanking and leading-zero suppression.
module digital_scan #(
  parameter int DIGITS         = 8,
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYCLES   = 16,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     en,
  input  logic                  lz_blank,
  output logic [6:0]            hex,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     sel
);
  import digital_pkg::*;

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIGITS-1:0] SEL_OFF =
    (SEL_ACTIVE_LOW != 0) ? '1 : '0;

  typedef struct packed {
    logic [4*DIGITS-1:0] data;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   en;
    logic                lz;
  } snap_t;

  snap_t         snap, snap_d;
  logic [CW-1:0] cnt_nx;
  logic [IW-1:0] idx_nx;
  logic          show_nx;
  logic          frame_start;

  logic [DIGITS-1:0] supp;
  logic [DIGITS-1:0] onehot;
  logic [3:0]        code;
  logic              dp_sel, en_sel, supp_sel, run;

  scan_timer #(
    .DIGITS       (DIGITS),
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .cnt_nx      (cnt_nx),
    .idx_nx      (idx_nx),
    .show_nx     (show_nx),
    .frame_start (frame_start)
  );

  always_comb begin
    snap_d = snap;
    if (frame_start) begin
      snap_d.data = data;
      snap_d.dp   = dp;
      snap_d.en   = en;
      snap_d.lz   = lz_blank;
    end
  end

  // Zero run from the top digit down; digit 0 always shows.
  always_comb begin
    supp = '0;
    run  = snap_d.lz;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      run     = run && (snap_d.data[4*i +: 4] == 4'h0);
      supp[i] = run;
    end
  end

  always_comb begin
    code     = '0;
    dp_sel   = 1'b0;
    en_sel   = 1'b0;
    supp_sel = 1'b0;
    onehot   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_nx == IW'(i)) begin
        code      = snap_d.data[4*i +: 4];
        dp_sel    = snap_d.dp[i];
        en_sel    = snap_d.en[i];
        supp_sel  = supp[i];
        onehot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snap   <= '0;
      hex    <= SEG_BLANK;
      dp_out <= 1'b1;
      sel    <= SEL_OFF;
    end else begin
      snap <= snap_d;
      if (show_nx && en_sel) begin
        hex    <= supp_sel ? SEG_BLANK : seg_decode(code);
        dp_out <= ~dp_sel;
        sel    <= (SEL_ACTIVE_LOW != 0) ? ~onehot : onehot;
      end else begin
        hex    <= SEG_BLANK;
        dp_out <= 1'b1;
        sel    <= SEL_OFF;
      end
    end
  end

endmodule

// File: tb/tb_digital_scan.sv
// Scoreboard bench for digital_scan: 4 digits, 8-cycle slots,
// 2 dead-time cycles, active-low select.
module tb_digital_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  en = '0;
  logic        lz_blank = 1'b0;
  logic [6:0]  hex;
  logic        dp_out;
  logic [3:0]  sel;

  int total = 0;
  int bad = 0;

  int          m_cnt = 0;
  int          m_idx = 0;
  logic [15:0] s_data = '0;
  logic [3:0]  s_dp = '0;
  logic [3:0]  s_en = '0;
  logic        s_lz = 1'b0;

  logic [11:0] q[$];
  logic [11:0] ex;

  localparam logic [6:0] SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h7F
  };

  digital_scan #(
    .DIGITS         (4),
    .SCAN_DIV       (8),
    .BLANK_CYCLES   (2),
    .SEL_ACTIVE_LOW (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data     (data),
    .dp       (dp),
    .en       (en),
    .lz_blank (lz_blank),
    .hex      (hex),
    .dp_out   (dp_out),
    .sel      (sel)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1);
  end

  function automatic logic [11:0] model_out(
    input int c, input int ix
  );
    logic [6:0] h;
    logic [3:0] cd;
    int top;
    if (c < 2 || !s_en[ix]) return {7'h7F, 1'b1, 4'hF};
    top = -1;
    for (int k = 0; k < 4; k++)
      if (s_data[4*k +: 4] != 4'h0) top = k;
    cd = s_data[4*ix +: 4];
    h = SEG[cd];
    if (s_lz && ix > top && ix != 0) h = 7'h7F;
    return {h, ~s_dp[ix], ~(4'b0001 << ix)};
  endfunction

  task automatic tick();
    if (rst) begin
      m_cnt = 0; m_idx = 0;
      s_data = '0; s_dp = '0; s_en = '0; s_lz = 1'b0;
    end else begin
      if (m_cnt == 0 && m_idx == 0) begin
        s_data = data; s_dp = dp;
        s_en = en; s_lz = lz_blank;
      end
      if (m_cnt == 7) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % 4;
      end else begin
        m_cnt++;
      end
    end
    q.push_back(model_out(m_cnt, m_idx));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    data = 16'h1234; en = 4'hF; dp = 4'h0; lz_blank = 1'b0;
    rst = 1'b1;
    tick(); void'(q.pop_front());
    rst = 1'b0;
    repeat (5) tick();
    repeat (5) void'(q.pop_front());
    rst = 1'b1;
    repeat (3) begin
      tick(); ex = q.pop_front();
      total++;
      if (hex !== 7'h7F || dp_out !== 1'b1 || sel !== 4'hF) begin
        bad++;
        $display("FAIL reset_hold: got %h/%b/%b want 7f/1/1111",
                 hex, dp_out, sel);
      end
      total++;
      if ({hex, dp_out, sel} !== ex) begin
        bad++;
        $display("FAIL reset_sb: got %h want %h",
                 {hex, dp_out, sel}, ex);
      end
    end
    rst = 1'b0;
    repeat (2) begin
      tick(); ex = q.pop_front();
      total++;
      if ({hex, dp_out, sel} !== ex) begin
        bad++;
        $display("FAIL reset_rel_sb: got %h want %h",
                 {hex, dp_out, sel}, ex);
      end
    end
    total++;
    if (sel !== 4'b1110 || hex !== 7'b0011001) begin
      bad++;
      $display("FAIL reset_digit0: got sel=%b hex=%b want 1110/0011001",
               sel, hex);
    end
  endtask

  task automatic test_basic();
    data = 16'h1234; en = 4'hF; dp = 4'b0010; lz_blank = 1'b0;
    rst = 1'b1; tick(); void'(q.pop_front()); rst = 1'b0;
    repeat (32) begin
      tick(); ex = q.pop_front();
      total++;
      if ({hex, dp_out, sel} !== ex) begin
        bad++;
        $display("FAIL basic_sb: got %h want %h idx=%0d cnt=%0d",
                 {hex, dp_out, sel}, ex, m_idx, m_cnt);
      end
      total++;
      if (m_cnt < 2) begin
        if (sel !== 4'hF) begin
          bad++;
          $display("FAIL basic_dead: got sel=%b want 1111", sel);
        end
      end else if (m_idx == 0) begin
        if (sel !== 4'b1110 || hex !== 7'b0011001) begin
          bad++;
          $display("FAIL basic_d0: got %b/%b want 1110/0011001", sel, hex);
        end
      end else if (m_idx == 1) begin
        if (sel !== 4'b1101 || hex !== 7'b0110000 || dp_out !== 1'b0) begin
          bad++;
          $display("FAIL basic_d1: got %b/%b/%b want 1101/0110000/0",
                   sel, hex, dp_out);
        end
      end else if (m_idx == 3) begin
        if (sel !== 4'b0111 || hex !== 7'b1111001) begin
          bad++;
          $display("FAIL basic_d3: got %b/%b want 0111/1111001", sel, hex);
        end
      end else if (sel !== 4'b1011) begin
        bad++;
        $display("FAIL basic_d2: got sel=%b want 1011", sel);
      end
    end
  endtask

  task automatic test_leading_zeros();
    data = 16'h0050; en = 4'hF; dp = 4'h0; lz_blank = 1'b1;
    rst = 1'b1; tick(); void'(q.pop_front()); rst = 1'b0;
    for (int f = 0; f < 2; f++) begin
      repeat (32) begin
        tick(); ex = q.pop_front();
        total++;
        if ({hex, dp_out, sel} !== ex) begin
          bad++;
          $display("FAIL lz_sb: got %h want %h idx=%0d cnt=%0d",
                   {hex, dp_out, sel}, ex, m_idx, m_cnt);
        end
        if (m_cnt >= 2) begin
          total++;
          if (m_idx == 0 && (hex !== 7'b1000000 || sel !== 4'b1110)) begin
            bad++;
            $display("FAIL lz_d0: got %b/%b want 1000000/1110", hex, sel);
          end else if (m_idx == 1 && f == 0 && hex !== 7'b0010010) begin
            bad++;
            $display("FAIL lz_d1: got %b want 0010010", hex);
          end else if (m_idx != 0 && (f == 1 || m_idx > 1) &&
                       (hex !== 7'h7F || sel[m_idx] !== 1'b0)) begin
            bad++;
            $display("FAIL lz_supp: got %b/%b want 1111111 sel on", hex, sel);
          end
        end
      end
      data = 16'h0000;
    end
  endtask

  task automatic test_snapshot();
    data = 16'h1234; en = 4'hF; dp = 4'h0; lz_blank = 1'b0;
    rst = 1'b1; tick(); void'(q.pop_front()); rst = 1'b0;
    for (int n = 0; n < 64; n++) begin
      if (n == 12) data = 16'h5678;
      tick(); ex = q.pop_front();
      total++;
      if ({hex, dp_out, sel} !== ex) begin
        bad++;
        $display("FAIL snap_sb: got %h want %h idx=%0d cnt=%0d",
                 {hex, dp_out, sel}, ex, m_idx, m_cnt);
      end
      if (m_cnt >= 2 && n < 32 && m_idx >= 2) begin
        total++;
        if (hex !== ((m_idx == 2) ? 7'b0100100 : 7'b1111001)) begin
          bad++;
          $display("FAIL snap_old: got %b at digit %0d", hex, m_idx);
        end
      end
      if (m_cnt >= 2 && n >= 32 && m_idx == 0) begin
        total++;
        if (hex !== 7'b0000000) begin
          bad++;
          $display("FAIL snap_new: got %b want 0000000", hex);
        end
      end
    end
  endtask

  task automatic test_enable_code15();
    data = 16'h1234; en = 4'b0101; dp = 4'hF; lz_blank = 1'b0;
    rst = 1'b1; tick(); void'(q.pop_front()); rst = 1'b0;
    repeat (96) begin
      tick(); ex = q.pop_front();
      total++;
      if ({hex, dp_out, sel} !== ex) begin
        bad++;
        $display("FAIL en_sb: got %h want %h", {hex, dp_out, sel}, ex);
      end
      total++;
      if (sel[1] !== 1'b1 || sel[3] !== 1'b1) begin
        bad++;
        $display("FAIL en_mask: got sel=%b want bits 1,3 high", sel);
      end
    end
    data = 16'hF012; en = 4'hF; dp = 4'h0; lz_blank = 1'b1;
    rst = 1'b1; tick(); void'(q.pop_front()); rst = 1'b0;
    repeat (32) begin
      tick(); ex = q.pop_front();
      total++;
      if ({hex, dp_out, sel} !== ex) begin
        bad++;
        $display("FAIL c15_sb: got %h want %h", {hex, dp_out, sel}, ex);
      end
      if (m_cnt >= 2 && m_idx >= 2) begin
        total++;
        if (m_idx == 3 && (hex !== 7'h7F || sel !== 4'b0111)) begin
          bad++;
          $display("FAIL c15_d3: got %b/%b want 1111111/0111", hex, sel);
        end else if (m_idx == 2 && hex !== 7'b1000000) begin
          bad++;
          $display("FAIL c15_d2: got %b want 1000000", hex);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    data = 16'h1234; en = 4'hF; dp = 4'h0; lz_blank = 1'b0;
    rst = 1'b1; tick(); void'(q.pop_front()); rst = 1'b0;
    repeat (21) begin
      tick(); ex = q.pop_front();
      total++;
      if ({hex, dp_out, sel} !== ex) begin
        bad++;
        $display("FAIL mid_pre_sb: got %h want %h", {hex, dp_out, sel}, ex);
      end
    end
    rst = 1'b1; data = 16'h5678;
    tick(); void'(q.pop_front());
    total++;
    if (hex !== 7'h7F || dp_out !== 1'b1 || sel !== 4'hF) begin
      bad++;
      $display("FAIL mid_reset: got %h/%b/%b want 7f/1/1111",
               hex, dp_out, sel);
    end
    rst = 1'b0;
    repeat (16) begin
      tick(); ex = q.pop_front();
      total++;
      if ({hex, dp_out, sel} !== ex) begin
        bad++;
        $display("FAIL mid_post_sb: got %h want %h", {hex, dp_out, sel}, ex);
      end
      if (m_cnt >= 2) begin
        total++;
        if (m_idx == 0 && (hex !== 7'b0000000 || sel !== 4'b1110)) begin
          bad++;
          $display("FAIL mid_d0: got %b/%b want 0000000/1110", hex, sel);
        end else if (m_idx == 1 && hex !== 7'b1111000) begin
          bad++;
          $display("FAIL mid_d1: got %b want 1111000", hex);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_leading_zeros();
    test_snapshot();
    test_enable_code15();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
